// File: rtl/seg_pkg.sv
// Shared constants and state type for the BCD-to-7-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int unsigned MAX_DISPLAY = 9999;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Nibbles above 9 cannot occur after double-dabble and are shown blank.
module seg7_encode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding four 7-segment
// encoders; registered segment outputs hold between conversions.
module bcd_seg_driver
  import seg_pkg::*;
#(
  parameter int IN_W = 14,
  parameter int LZB  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [6:0]      seg0,
  output logic [6:0]      seg1,
  output logic [6:0]      seg2,
  output logic [6:0]      seg3
);

  localparam logic [IN_W-1:0] MAX_V    = IN_W'(MAX_DISPLAY);
  localparam logic [3:0]      LAST_CNT = 4'(IN_W - 1);

  state_t          state;
  logic [IN_W-1:0] bin;
  logic [15:0]     bcd;
  logic [15:0]     adj;
  logic [3:0]      cnt;
  logic            ovf;
  logic [6:0]      enc [4];
  logic [6:0]      nxt [4];

  assign busy = (state != IDLE);

  // Add-3 correction on every nibble before the shift; 4-bit, no carry out.
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_enc
    seg7_encode u_enc (
      .bcd (bcd[g*4 +: 4]),
      .seg (enc[g])
    );
  end

  // Overflow wins over blanking; blanking cascades from the thousands digit down.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) nxt[i] = enc[i];
    if (ovf) begin
      for (int unsigned i = 0; i < 4; i++) nxt[i] = SEG_DASH;
    end else if (LZB != 0) begin
      if (bcd[15:12] == 4'd0) nxt[3] = SEG_BLANK;
      if (bcd[15:8]  == 8'd0) nxt[2] = SEG_BLANK;
      if (bcd[15:4]  == 12'd0) nxt[1] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      seg0  <= SEG_BLANK;
      seg1  <= SEG_BLANK;
      seg2  <= SEG_BLANK;
      seg3  <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin   <= value;
            bcd   <= '0;
            cnt   <= '0;
            ovf   <= (value > MAX_V);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {adj[14:0], bin[IN_W-1]};
          bin <= {bin[IN_W-2:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) state <= ENCODE;
        end
        ENCODE: begin
          seg0  <= nxt[0];
          seg1  <= nxt[1];
          seg2  <= nxt[2];
          seg3  <= nxt[3];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Scoreboard bench for bcd_seg_driver: stimulus pushes expected segment
// words {seg3,seg2,seg1,seg0}; monitors pop and compare on each done pulse.
module tb_bcd_seg_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_nz = 1'b0;
  logic [13:0] value = '0;
  logic        busy, done, busy_nz, done_nz;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic [6:0]  nz0, nz1, nz2, nz3;

  int total = 0;
  int bad   = 0;
  int run    = 0;
  int run_nz = 0;
  logic [27:0] sb    [$];
  logic [27:0] sb_nz [$];

  always #5 clk = ~clk;

  bcd_seg_driver #(.IN_W(14), .LZB(1)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
  );

  bcd_seg_driver #(.IN_W(14), .LZB(0)) dut_nz (
    .clk(clk), .rst(rst), .start(start_nz), .value(value),
    .busy(busy_nz), .done(done_nz),
    .seg0(nz0), .seg1(nz1), .seg2(nz2), .seg3(nz3)
  );

  // Monitor for the blanking-enabled instance.
  always @(negedge clk) begin
    logic [27:0] e;
    if (rst) begin
      run = 0;
    end else begin
      if (busy) run++;
      if (done) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done got=%h,%h,%h,%h required=no done", seg3, seg2, seg1, seg0);
        end else begin
          e = sb.pop_front();
          if ({seg3, seg2, seg1, seg0} !== e) begin
            bad++;
            $display("FAIL segs got=%h,%h,%h,%h required=%h,%h,%h,%h",
                     seg3, seg2, seg1, seg0, e[27:21], e[20:14], e[13:7], e[6:0]);
          end
        end
        total++;
        if (run != 15) begin
          bad++;
          $display("FAIL busy_len got=%0d required=15", run);
        end
        run = 0;
      end
    end
  end

  // Monitor for the instance without leading-zero blanking.
  always @(negedge clk) begin
    logic [27:0] e;
    if (rst) begin
      run_nz = 0;
    end else begin
      if (busy_nz) run_nz++;
      if (done_nz) begin
        total++;
        if (sb_nz.size() == 0) begin
          bad++;
          $display("FAIL nz_unexpected_done got=%h,%h,%h,%h required=no done", nz3, nz2, nz1, nz0);
        end else begin
          e = sb_nz.pop_front();
          if ({nz3, nz2, nz1, nz0} !== e) begin
            bad++;
            $display("FAIL nz_segs got=%h,%h,%h,%h required=%h,%h,%h,%h",
                     nz3, nz2, nz1, nz0, e[27:21], e[20:14], e[13:7], e[6:0]);
          end
        end
        total++;
        if (run_nz != 15) begin
          bad++;
          $display("FAIL nz_busy_len got=%0d required=15", run_nz);
        end
        run_nz = 0;
      end
    end
  end

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && sb_nz.size() == 0) return;
      @(posedge clk);
    end
    total++;
    bad++;
    $display("FAIL timeout_%s got=pending %0d/%0d required=0", tag, sb.size(), sb_nz.size());
  endtask

  task automatic convert(input logic [13:0] v, input logic [27:0] exp_segs);
    @(posedge clk);
    #1;
    sb.push_back(exp_segs);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty("convert");
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({seg3, seg2, seg1, seg0} !== {4{7'h7F}} || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle got segs=%h busy=%b done=%b required segs=%h busy=0 done=0",
                 {seg3, seg2, seg1, seg0}, busy, done, {4{7'h7F}});
      end
    end

    convert(14'd1234,  {7'h79, 7'h24, 7'h30, 7'h19});
    convert(14'd42,    {7'h7F, 7'h7F, 7'h19, 7'h24});
    convert(14'd0,     {7'h7F, 7'h7F, 7'h7F, 7'h40});
    convert(14'd100,   {7'h7F, 7'h79, 7'h40, 7'h40});
    convert(14'd1000,  {7'h79, 7'h40, 7'h40, 7'h40});
    convert(14'd9999,  {7'h10, 7'h10, 7'h10, 7'h10});
    convert(14'd10000, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    convert(14'd16383, {7'h3F, 7'h3F, 7'h3F, 7'h3F});

    // Value 0 without blanking shows four zeros.
    @(posedge clk);
    #1;
    sb_nz.push_back({7'h40, 7'h40, 7'h40, 7'h40});
    start_nz = 1'b1;
    value = 14'd0;
    @(posedge clk);
    #1 start_nz = 1'b0;
    wait_empty("nz");

    // Start during busy is ignored; start in the done cycle is accepted.
    @(posedge clk);
    #1;
    sb.push_back({7'h79, 7'h24, 7'h30, 7'h19});
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    value = 14'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 14'd1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL timeout_first_done got=no done required=done");
      end
    end
    sb.push_back({7'h12, 7'h02, 7'h78, 7'h00});
    start = 1'b1;
    value = 14'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 14'd3;
    wait_empty("b2b");

    // Reset mid-conversion: no done must follow for the aborted request.
    @(posedge clk);
    #1;
    start = 1'b1;
    value = 14'd4321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || {seg3, seg2, seg1, seg0} !== {4{7'h7F}}) begin
      bad++;
      $display("FAIL abort_reset got busy=%b segs=%h required busy=0 segs=%h",
               busy, {seg3, seg2, seg1, seg0}, {4{7'h7F}});
    end
    rst = 1'b0;
    repeat (25) @(posedge clk);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
